// File: rtl/rxuart_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM encoding, frame width and
// the default bit period shared with txuart.
package rxuart_pkg;

  localparam int          DATA_BITS               = 8;
  localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd1250;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Delay from the detected falling edge to the start-bit centre.
  function automatic logic [23:0] half_baud_load(input logic [23:0] clocks_per_baud);
    return (clocks_per_baud >> 1) - 24'd1;
  endfunction

endpackage

// File: rtl/rxuart_if.sv
// Serial line plus received-byte strobes of rxuart; slave is the receiver side,
// master is the side driving the line and consuming the bytes.
interface rxuart_if;
  import rxuart_pkg::*;

  logic                 i_uart_rx;
  logic                 o_wr;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_busy;

  modport master (
    output i_uart_rx,
    input  o_wr, o_data, o_frame_err, o_break, o_busy
  );

  modport slave (
    input  i_uart_rx,
    output o_wr, o_data, o_frame_err, o_break, o_busy
  );

endinterface

// File: rtl/rxuart_sync.sv
// Two-flop synchroniser for asynchronous inputs with a selectable reset value.
module rxuart_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  assign dout = sync;

endmodule

// File: rtl/rxuart.sv
// Fixed-baud 8N1 UART receiver: mid-bit start qualification, LSB-first data
// sampling at bit centres, stop-bit check with frame-error and break reporting.
module rxuart
  import rxuart_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  rxuart_if.slave  bus
);

  localparam logic [23:0] HALF_LOAD = half_baud_load(CLOCKS_PER_BAUD);
  localparam logic [23:0] FULL_LOAD = CLOCKS_PER_BAUD - 24'd1;
  localparam logic [2:0]  LAST_IDX  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state,     state_nxt;
  logic [23:0]          cnt,       cnt_nxt;
  logic [2:0]           idx,       idx_nxt;
  logic [DATA_BITS-1:0] shreg,     shreg_nxt;
  logic [DATA_BITS-1:0] data_q,    data_nxt;
  logic                 wr_q,      wr_nxt;
  logic                 ferr_q,    ferr_nxt;
  logic                 brk_q,     brk_nxt;
  logic                 tick;

  rxuart_sync #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .din     (bus.i_uart_rx),
    .dout    (rx_s)
  );

  assign tick = (cnt == 24'd0);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      cnt    <= 24'd0;
      idx    <= 3'd0;
      shreg  <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      ferr_q <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      shreg  <= shreg_nxt;
      data_q <= data_nxt;
      wr_q   <= wr_nxt;
      ferr_q <= ferr_nxt;
      brk_q  <= brk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    wr_nxt    = 1'b0;
    ferr_nxt  = 1'b0;
    brk_nxt   = brk_q;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_nxt   = HALF_LOAD;
          state_nxt = START;
        end
      end

      START: begin
        if (!tick) begin
          cnt_nxt = cnt - 24'd1;
        end else if (rx_s) begin
          // Line went back high before mid-bit: treat as a glitch.
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = FULL_LOAD;
          idx_nxt   = 3'd0;
          state_nxt = DATA;
        end
      end

      DATA: begin
        if (!tick) begin
          cnt_nxt = cnt - 24'd1;
        end else begin
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          cnt_nxt   = FULL_LOAD;
          if (idx == LAST_IDX) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end

      STOP: begin
        if (!tick) begin
          cnt_nxt = cnt - 24'd1;
        end else if (rx_s) begin
          data_nxt  = shreg;
          wr_nxt    = 1'b1;
          state_nxt = IDLE;
        end else begin
          // An all-zero frame with a low stop bit means the line is held low.
          ferr_nxt  = 1'b1;
          state_nxt = WAIT_IDLE;
          if (shreg != '0) begin
            data_nxt = shreg;
          end else begin
            brk_nxt = 1'b1;
          end
        end
      end

      WAIT_IDLE: begin
        if (rx_s) begin
          brk_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.o_wr        = wr_q;
  assign bus.o_data      = data_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_break     = brk_q;
  assign bus.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_rxuart.sv
// Scoreboard bench for rxuart at 16 clocks per bit.
module tb_rxuart;

  localparam int CPB     = 16;
  localparam int LATENCY = 2 + CPB / 2 + 9 * CPB + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       i_clk;
  logic       reset_n;
  int         cyc;
  int         checks;
  int         failures;
  logic [7:0] model_data;
  exp_t       sb[$];
  exp_t       e;

  rxuart_if bus();

  rxuart #(
    .CLOCKS_PER_BAUD (24'(CPB))
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (bus.o_wr || bus.o_frame_err) begin
      chk("strobe_exclusive", 32'(bus.o_wr & bus.o_frame_err), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", 32'(bus.o_frame_err), 32'(e.err));
        chk("strobe_data", 32'(bus.o_data), 32'(e.data));
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push_exp(input bit err, input logic [7:0] d);
    exp_t x;
    x.err  = err;
    x.data = d;
    x.cyc  = cyc + LATENCY;
    sb.push_back(x);
  endtask

  // Called at a negedge; drives one full frame, leaving the stop level on the line.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      push_exp(1'b0, b);
      model_data = b;
    end else if (b != 8'h00) begin
      push_exp(1'b1, b);
      model_data = b;
    end else begin
      push_exp(1'b1, model_data);
    end
    bus.i_uart_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      bus.i_uart_rx = b[i];
      repeat (CPB) @(negedge i_clk);
    end
    bus.i_uart_rx = stop;
    repeat (CPB) @(negedge i_clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr"},   32'(bus.o_wr),        32'd0);
    chk({tag, "_ferr"}, 32'(bus.o_frame_err), 32'd0);
    chk({tag, "_brk"},  32'(bus.o_break),     32'd0);
    chk({tag, "_data"}, 32'(bus.o_data),      32'd0);
    chk({tag, "_busy"}, 32'(bus.o_busy),      32'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    model_data    = 8'h00;
    bus.i_uart_rx = 1'b1;
    reset_n       = 1'b0;
    repeat (3) @(negedge i_clk);
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (10) @(negedge i_clk);

    // Single clean byte.
    send_frame(8'h48, 1'b1);
    repeat (20) @(negedge i_clk);
    chk("h_data_hold", 32'(bus.o_data), 32'h48);
    chk("h_busy", 32'(bus.o_busy), 32'd0);

    // Two frames with no idle gap.
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    repeat (20) @(negedge i_clk);
    chk("b2b_data", 32'(bus.o_data), 32'hA3);

    // Short glitch must not start a frame.
    bus.i_uart_rx = 1'b0;
    repeat (5) @(negedge i_clk);
    bus.i_uart_rx = 1'b1;
    repeat (10) @(negedge i_clk);
    chk("glitch_busy", 32'(bus.o_busy), 32'd0);
    chk("glitch_data", 32'(bus.o_data), 32'hA3);
    repeat (10) @(negedge i_clk);

    // Framing error with the line then held low.
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge i_clk);
    chk("ferr_wait_busy", 32'(bus.o_busy), 32'd1);
    chk("ferr_no_break", 32'(bus.o_break), 32'd0);
    chk("ferr_data", 32'(bus.o_data), 32'h3C);
    bus.i_uart_rx = 1'b1;
    repeat (4) @(negedge i_clk);
    chk("ferr_release_busy", 32'(bus.o_busy), 32'd0);
    repeat (20) @(negedge i_clk);

    // Break: line low for 400 cycles.
    push_exp(1'b1, model_data);
    bus.i_uart_rx = 1'b0;
    repeat (200) @(negedge i_clk);
    chk("break_set", 32'(bus.o_break), 32'd1);
    chk("break_busy", 32'(bus.o_busy), 32'd1);
    repeat (200) @(negedge i_clk);
    chk("break_held", 32'(bus.o_break), 32'd1);
    bus.i_uart_rx = 1'b1;
    repeat (4) @(negedge i_clk);
    chk("break_clear", 32'(bus.o_break), 32'd0);
    chk("break_data", 32'(bus.o_data), 32'h3C);
    repeat (20) @(negedge i_clk);

    // Reset during data bit 4 of 8'hFF aborts the frame.
    bus.i_uart_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    bus.i_uart_rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge i_clk);
    reset_n = 1'b0;
    @(negedge i_clk);
    chk_outputs_zero("midreset");
    reset_n    = 1'b1;
    model_data = 8'h00;
    repeat (8 * CPB) @(negedge i_clk);
    chk("abort_no_busy", 32'(bus.o_busy), 32'd0);

    send_frame(8'h0F, 1'b1);
    repeat (20) @(negedge i_clk);
    chk("post_reset_data", 32'(bus.o_data), 32'h0F);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
